// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control definitions: encoder FSM states and lane codes
// common to the 2x4 select decoder and the 4x2 round-robin encoder.
package alu_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic [1:0] LANE0 = 2'd0;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE2 = 2'd2;
  localparam logic [1:0] LANE3 = 2'd3;

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker: first set bit of req at or after
// lane start, wrapping modulo 4.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] start,
  output logic       any,
  output logic [1:0] idx,
  output logic [3:0] onehot
);

  logic [1:0] cand;

  // Scan the farthest candidate first so the nearest set lane overwrites it.
  always_comb begin
    any  = 1'b0;
    idx  = start;
    cand = start;
    for (int k = 3; k >= 0; k--) begin
      cand = start + 2'(k);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

  always_comb begin
    onehot = 4'b0000;
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/encoder_4x2_rr.sv
// Sequential 4-to-2 encoder: sticky pending set from four lane strobes,
// round-robin encoded one lane at a time onto a valid/ready code output.
module encoder_4x2_rr
  import alu_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req0,
  input  logic             req1,
  input  logic             req2,
  input  logic             req3,
  output logic [1:0]       code,
  output logic             code_valid,
  input  logic             code_ready,
  output logic [3:0]       pending,
  output logic             overrun,
  output logic [CNT_W-1:0] grant_cnt,
  output state_t           dbg_state
);

  // Handshake: code/code_valid are held stable while code_valid=1 and
  // code_ready=0; a transfer completes on each edge with both high.

  state_t           st, st_n;
  logic [1:0]       code_n;
  logic [1:0]       last, last_n;
  logic [CNT_W-1:0] cnt_n;
  logic [3:0]       req_v;
  logic [3:0]       clr;
  logic [3:0]       pending_n;
  logic             ovr_hit;

  logic             a_any, b_any;
  logic [1:0]       a_idx, b_idx;
  logic [3:0]       a_oh, b_oh;

  assign req_v = {req3, req2, req1, req0};

  // Idle load resumes after the last accepted lane.
  rr_pick4 u_pick_idle (
    .req    (pending),
    .start  (last + 2'd1),
    .any    (a_any),
    .idx    (a_idx),
    .onehot (a_oh)
  );

  // Back-to-back reload continues after the lane being accepted now.
  rr_pick4 u_pick_reload (
    .req    (pending),
    .start  (code + 2'd1),
    .any    (b_any),
    .idx    (b_idx),
    .onehot (b_oh)
  );

  always_comb begin
    st_n   = st;
    code_n = code;
    last_n = last;
    cnt_n  = grant_cnt;
    clr    = 4'b0000;
    case (st)
      ST_IDLE: begin
        if (a_any) begin
          code_n = a_idx;
          clr    = a_oh;
          st_n   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (code_ready) begin
          cnt_n  = grant_cnt + CNT_W'(1);
          last_n = code;
          if (b_any) begin
            code_n = b_idx;
            clr    = b_oh;
          end else begin
            st_n = ST_IDLE;
          end
        end
      end
      default: st_n = ST_IDLE;
    endcase
  end

  // A new request on the bit being cleared is kept: set wins, no overrun.
  assign pending_n = (pending & ~clr) | req_v;
  assign ovr_hit   = |(req_v & pending & ~clr);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st        <= ST_IDLE;
      code      <= LANE0;
      last      <= LANE3;
      pending   <= 4'b0000;
      overrun   <= 1'b0;
      grant_cnt <= '0;
    end else begin
      st        <= st_n;
      code      <= code_n;
      last      <= last_n;
      pending   <= pending_n;
      grant_cnt <= cnt_n;
      if (ovr_hit) overrun <= 1'b1;
    end
  end

  assign code_valid = (st == ST_HOLD);
  assign dbg_state  = st;

endmodule

// File: tb/tb_encoder_4x2_rr.sv
// Bench for encoder_4x2_rr: directed scenarios plus random traffic checked
// against a lane-array reference model through an expected-code queue.
module tb_encoder_4x2_rr;
  import alu_ctrl_pkg::*;

  localparam int CNT_W = 8;

  logic             CLK;
  logic             RST;
  logic             req0, req1, req2, req3;
  logic [1:0]       code;
  logic             code_valid;
  logic             code_ready;
  logic [3:0]       pending;
  logic             overrun;
  logic [CNT_W-1:0] grant_cnt;
  state_t           dbg_state;

  int vectors;
  int miscompares;

  encoder_4x2_rr #(.CNT_W(CNT_W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req0       (req0),
    .req1       (req1),
    .req2       (req2),
    .req3       (req3),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .pending    (pending),
    .overrun    (overrun),
    .grant_cnt  (grant_cnt),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // reference model state
  bit         mp[4];
  int         m_last;
  int         m_cur;
  bit         m_busy;
  bit         m_ovr;
  int         m_cnt;
  logic [1:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int search(input int start);
    for (int k = 0; k < 4; k++) begin
      if (mp[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  function automatic int model_pending();
    int v = 0;
    for (int i = 0; i < 4; i++) if (mp[i]) v += (1 << i);
    return v;
  endfunction

  // model advances on the same edge as the DUT, seeing pre-edge inputs
  always @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < 4; i++) mp[i] = 1'b0;
      m_last = 3; m_cur = 0; m_busy = 1'b0; m_ovr = 1'b0; m_cnt = 0;
      exp_q.delete();
    end else begin
      int  load;
      bit  r[4];
      r[0] = req0; r[1] = req1; r[2] = req2; r[3] = req3;
      load = -1;
      if (!m_busy) begin
        load = search(m_last + 1);
      end else if (code_ready) begin
        m_cnt  = (m_cnt + 1) % (1 << CNT_W);
        m_last = m_cur;
        m_busy = 1'b0;
        load   = search(m_cur + 1);
      end
      if (load >= 0) begin
        m_busy = 1'b1;
        m_cur  = load;
        exp_q.push_back(2'(load));
      end
      for (int i = 0; i < 4; i++) begin
        if (r[i] && mp[i] && i != load) m_ovr = 1'b1;
        mp[i] = (mp[i] && i != load) || r[i];
      end
    end
  end

  // monitor: mid-cycle, compare outputs and retire codes on handshakes
  always @(negedge CLK) begin
    if (RST) begin
      check("code_valid", int'(code_valid), int'(m_busy));
      check("pending", int'(pending), model_pending());
      check("overrun", int'(overrun), int'(m_ovr));
      check("grant_cnt", int'(grant_cnt), m_cnt);
      if (code_valid) begin
        if (exp_q.size() == 0) begin
          check("code_unexpected", int'(code), -1);
        end else begin
          check("code", int'(code), int'(exp_q[0]));
          if (code_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic step(input logic [3:0] r, input logic rdy);
    @(posedge CLK);
    #1;
    {req3, req2, req1, req0} = r;
    code_ready = rdy;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(4'b0000, rdy);
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    {req3, req2, req1, req0} = 4'b0000;
    code_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
  endtask

  task automatic random_run(input int n);
    logic [3:0] r;
    for (int i = 0; i < n; i++) begin
      r = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      step(r, ($urandom_range(0, 3) != 0));
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    RST = 1'b0;
    {req3, req2, req1, req0} = 4'b0000;
    code_ready = 1'b0;
    #2;
    check("rst_code_valid", int'(code_valid), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_grant_cnt", int'(grant_cnt), 0);
    check("rst_code", int'(code), 0);
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
    idle(20, 1'b1);

    // single request, explicit two-edge latency
    step(4'b0100, 1'b1);
    step(4'b0000, 1'b1);
    #1;
    check("single_lat1_valid", int'(code_valid), 0);
    step(4'b0000, 1'b1);
    #1;
    check("single_valid", int'(code_valid), 1);
    check("single_code", int'(code), 2);
    idle(3, 1'b1);
    check("single_cnt", int'(grant_cnt), 1);

    // fairness: all four, then lanes 0 and 3
    step(4'b1111, 1'b1);
    idle(6, 1'b1);
    check("fair_cnt", int'(grant_cnt), 5);
    step(4'b1001, 1'b1);
    idle(5, 1'b1);

    // backpressure
    step(4'b1010, 1'b0);
    idle(5, 1'b0);
    idle(4, 1'b1);

    // overrun: lane 1 in flight, re-requested twice while stalled
    step(4'b1010, 1'b0);
    idle(2, 1'b0);
    step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);
    #1;
    check("overrun_set", int'(overrun), 1);
    idle(6, 1'b1);

    // set wins over clear on the load cycle
    do_reset();
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);
    #1;
    check("setwin_pending", int'(pending), 1);
    check("setwin_overrun", int'(overrun), 0);
    idle(4, 1'b1);

    random_run(1500);

    // asynchronous reset between edges while holding a grant
    step(4'b0110, 1'b0);
    idle(2, 1'b0);
    @(posedge CLK);
    #3;
    check("pre_async_valid", int'(code_valid), 1);
    RST = 1'b0;
    #1;
    check("async_valid", int'(code_valid), 0);
    check("async_pending", int'(pending), 0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    idle(3, 1'b1);
    step(4'b1001, 1'b1);
    idle(2, 1'b1);
    #1;
    check("post_rst_lane0_first", int'(code), 0);
    idle(4, 1'b1);

    random_run(800);
    idle(10, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
